// File: rtl/ldo_pkg.sv
// Shared definitions for the LDO trim-and-monitor controller.
package ldo_pkg;

  localparam int TRIM_W_DEF = 5;
  localparam int SETTLE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_MONITOR = 2'd3
  } ldo_state_t;

endpackage

// File: rtl/ldo_sync2.sv
// Two-flop synchronizer for a single asynchronous comparator input.
module ldo_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops so downstream logic sees a clean level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ldo_trim_ctrl.sv
// LDO trim controller: successive-approximation search of the reference trim
// code against the output comparator, then debounced undervoltage monitoring.
module ldo_trim_ctrl
  import ldo_pkg::*;
#(
  parameter int TRIM_W = TRIM_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              cmp_hi,
  input  logic              uv,
  output logic [TRIM_W-1:0] trim,
  output logic              busy,
  output logic              done,
  output logic              pgood,
  output logic              fault
);

  localparam int IW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam int CW = $clog2(SETTLE);
  localparam logic [TRIM_W-1:0] TRIM_MSB = TRIM_W'(1) << (TRIM_W - 1);

  ldo_state_t        state;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     dcnt;
  logic              cmp_s;
  logic              uv_s;
  logic [TRIM_W-1:0] bit_cur;
  logic [TRIM_W-1:0] bit_next;
  logic [TRIM_W-1:0] trim_dec;
  logic [TRIM_W-1:0] trim_step;
  logic              uv_disagree;

  ldo_sync2 u_sync_cmp (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_hi),
    .q     (cmp_s)
  );

  ldo_sync2 u_sync_uv (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uv),
    .q     (uv_s)
  );

  // SAR decision for the bit under test, plus the trial bit for the next step
  always_comb begin
    bit_cur   = TRIM_W'(1) << idx;
    bit_next  = TRIM_W'(1) << (idx - IW'(1));
    trim_dec  = cmp_s ? (trim & ~bit_cur) : trim;
    trim_step = (idx != '0) ? (trim_dec | bit_next) : trim_dec;
  end

  // pgood high expects uv_s low, so equal values mean the comparator disagrees
  assign uv_disagree = (uv_s == pgood);

  // Main controller: tile enable overrides everything, then the search/monitor FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      trim  <= '0;
      idx   <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pgood <= 1'b0;
      fault <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!ena) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        pgood <= 1'b0;
        cnt   <= '0;
        dcnt  <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_MONITOR: begin
            if (start) begin
              trim  <= TRIM_MSB;
              idx   <= IW'(TRIM_W - 1);
              fault <= 1'b0;
              cnt   <= '0;
              dcnt  <= '0;
              busy  <= 1'b1;
              pgood <= 1'b0;
              state <= ST_SETTLE;
            end else if (state == ST_MONITOR) begin
              if (!uv_disagree) begin
                dcnt <= '0;
              end else if (dcnt == CW'(SETTLE - 1)) begin
                dcnt  <= '0;
                pgood <= ~pgood;
              end else begin
                dcnt <= dcnt + CW'(1);
              end
            end
          end
          ST_SETTLE: begin
            if (cnt == CW'(SETTLE - 1)) begin
              cnt   <= '0;
              state <= ST_SAMPLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_SAMPLE: begin
            trim <= trim_step;
            if (idx != '0) begin
              idx   <= idx - IW'(1);
              state <= ST_SETTLE;
            end else begin
              state <= ST_MONITOR;
              busy  <= 1'b0;
              done  <= 1'b1;
              pgood <= 1'b0;
              dcnt  <= '0;
              fault <= (trim_dec == '0) || (trim_dec == '1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
